// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package pipe_pkg;

  // Slot address width; top-level REG_ADDR_W must not exceed this.
  localparam int unsigned SLOT_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_ADDR_W-1:0] rs;
    logic [SLOT_ADDR_W-1:0] rt;
    logic [SLOT_ADDR_W-1:0] dst;
    logic                   reg_write;
    logic                   mem_read;
  } slot_t;

  // Register 0 is hard-wired, so it never produces a hazard or a forward.
  function automatic logic slot_writes(input slot_t s, input logic [SLOT_ADDR_W-1:0] r);
    return s.valid && s.reg_write && (s.dst == r) && (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input slot_t m, input slot_t w,
                                         input logic [SLOT_ADDR_W-1:0] r);
    if (slot_writes(m, r))      return FWD_MEM;
    else if (slot_writes(w, r)) return FWD_WB;
    else                        return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_track_slot.sv
// One shadow pipeline slot: advances every cycle, loads a bubble on request.
module pipe_track_slot
  import pipe_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk) begin
    if (rst || bubble) q <= '0;
    else               q <= d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use/RAW interlock, EX operand forwarding, branch flush and event
// counters for a 5-stage MIPS pipeline, driven from shadow EX/MEM/WB slots.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
  parameter int unsigned BRANCH_STAGE = 3,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  slot_t id_slot, ex_q, mem_q, wb_q;
  logic  rst_q, gate, dep_ex, dep_mem, dep_wb, hazard, stall, flush;
  logic  [SLOT_ADDR_W-1:0] rs_s, rt_s;

  assign rs_s = SLOT_ADDR_W'(id_rs);
  assign rt_s = SLOT_ADDR_W'(id_rt);

  assign id_slot = '{valid:     id_valid,
                     rs:        rs_s,
                     rt:        rt_s,
                     dst:       SLOT_ADDR_W'(id_dst),
                     reg_write: id_reg_write,
                     mem_read:  id_mem_read};

  pipe_track_slot u_ex  (.clk(clk), .rst(rst), .bubble(idex_flush),  .d(id_slot), .q(ex_q));
  pipe_track_slot u_mem (.clk(clk), .rst(rst), .bubble(exmem_flush), .d(ex_q),    .q(mem_q));
  pipe_track_slot u_wb  (.clk(clk), .rst(rst), .bubble(1'b0),        .d(mem_q),   .q(wb_q));

  logic unused_wb;
  assign unused_wb = ^{wb_q.rs, wb_q.rt, wb_q.mem_read};

  // ID depends on a slot when a source it actually reads is that slot's destination.
  assign dep_ex  = id_valid && ((id_uses_rs && slot_writes(ex_q,  rs_s)) ||
                                (id_uses_rt && slot_writes(ex_q,  rt_s)));
  assign dep_mem = id_valid && ((id_uses_rs && slot_writes(mem_q, rs_s)) ||
                                (id_uses_rt && slot_writes(mem_q, rt_s)));
  assign dep_wb  = id_valid && ((id_uses_rs && slot_writes(wb_q,  rs_s)) ||
                                (id_uses_rt && slot_writes(wb_q,  rt_s)));

  assign hazard = (FWD_EN != 0) ? (dep_ex && ex_q.mem_read) : (dep_ex || dep_mem || dep_wb);

  // Controls are held idle during reset and the cycle after it.
  assign gate = rst || rst_q;

  always_comb begin
    flush       = 1'b0;
    stall       = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (!gate) begin
      flush       = br_taken;
      stall       = hazard && !br_taken;
      pc_en       = !stall;
      ifid_en     = !stall;
      ifid_flush  = flush;
      idex_flush  = flush || stall;
      exmem_flush = flush && (BRANCH_STAGE == 3);
      if (FWD_EN != 0) begin
        fwd_a = fwd_sel(mem_q, wb_q, ex_q.rs);
        fwd_b = fwd_sel(mem_q, wb_q, ex_q.rt);
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut_a uses defaults, dut_b has no forwarding, EX branches, 4-bit counters.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } ins_t;

  typedef struct {
    ins_t       i;
    logic       br;
    logic [8:0] exp;
  } vec_t;

  logic clk, rst, id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, br_taken;
  logic [4:0] id_rs, id_rt, id_dst;

  logic pc_en_a, ifid_en_a, ifid_flush_a, idex_flush_a, exmem_flush_a;
  logic [1:0] fwd_a_a, fwd_b_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic pc_en_b, ifid_en_b, ifid_flush_b, idex_flush_b, exmem_flush_b;
  logic [1:0] fwd_a_b, fwd_b_b;
  logic [3:0] stall_cnt_b, flush_cnt_b;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .exmem_flush(exmem_flush_a),
    .fwd_a(fwd_a_a), .fwd_b(fwd_b_a), .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_STAGE(2), .FWD_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .br_taken(br_taken),
    .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .exmem_flush(exmem_flush_b),
    .fwd_a(fwd_a_b), .fwd_b(fwd_b_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam ins_t NOP = '0;

  function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] s, input logic [4:0] t);
    return '{v:1'b1, rs:s, rt:t, urs:1'b1, urt:1'b1, dst:rd, rw:1'b1, mr:1'b0};
  endfunction

  function automatic ins_t lw(input logic [4:0] rd, input logic [4:0] base);
    return '{v:1'b1, rs:base, rt:5'd0, urs:1'b1, urt:1'b0, dst:rd, rw:1'b1, mr:1'b1};
  endfunction

  // Expected {pc_en, ifid_en, ifid_flush, idex_flush, exmem_flush, fwd_a, fwd_b}
  function automatic logic [8:0] e_ok(input logic [1:0] fa, input logic [1:0] fb);
    return {5'b11000, fa, fb};
  endfunction
  localparam logic [8:0] E_STALL  = 9'b00010_0000;
  localparam logic [8:0] E_FLUSH3 = 9'b11111_0000;
  localparam logic [8:0] E_FLUSH2 = 9'b11110_0000;

  function automatic logic [8:0] outs_a();
    return {pc_en_a, ifid_en_a, ifid_flush_a, idex_flush_a, exmem_flush_a, fwd_a_a, fwd_b_a};
  endfunction
  function automatic logic [8:0] outs_b();
    return {pc_en_b, ifid_en_b, ifid_flush_b, idex_flush_b, exmem_flush_b, fwd_a_b, fwd_b_b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input ins_t i, input logic b, input logic r);
    @(negedge clk);
    id_valid     = i.v;
    id_rs        = i.rs;
    id_rt        = i.rt;
    id_uses_rs   = i.urs;
    id_uses_rt   = i.urt;
    id_dst       = i.dst;
    id_reg_write = i.rw;
    id_mem_read  = i.mr;
    br_taken     = b;
    rst          = r;
    #1;
  endtask

  task automatic do_reset();
    step(NOP, 1'b0, 1'b1);
    step(NOP, 1'b0, 1'b0);
  endtask

  vec_t tbl[16];

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_dst = 0; id_reg_write = 0; id_mem_read = 0; br_taken = 0;

    tbl[0]  = '{lw(2, 0),     1'b0, e_ok(2'b00, 2'b00)};
    tbl[1]  = '{alu(3, 2, 4), 1'b0, E_STALL};
    tbl[2]  = '{alu(3, 2, 4), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[3]  = '{alu(5, 8, 9), 1'b0, e_ok(2'b01, 2'b00)};
    tbl[4]  = '{alu(6, 5, 3), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[5]  = '{alu(7, 5, 1), 1'b0, e_ok(2'b10, 2'b01)};
    tbl[6]  = '{NOP,          1'b0, e_ok(2'b01, 2'b00)};
    tbl[7]  = '{alu(0, 8, 9), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[8]  = '{alu(4, 0, 0), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[9]  = '{NOP,          1'b0, e_ok(2'b00, 2'b00)};
    tbl[10] = '{lw(0, 0),     1'b0, e_ok(2'b00, 2'b00)};
    tbl[11] = '{alu(3, 0, 0), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[12] = '{lw(2, 0),     1'b0, e_ok(2'b00, 2'b00)};
    tbl[13] = '{alu(3, 2, 4), 1'b1, E_FLUSH3};
    tbl[14] = '{alu(3, 2, 4), 1'b0, e_ok(2'b00, 2'b00)};
    tbl[15] = '{NOP,          1'b0, e_ok(2'b00, 2'b00)};

    // Reset state
    step(NOP, 1'b0, 1'b1);
    chk("rst_cycle_outs_a", 32'(outs_a()), 32'(e_ok(2'b00, 2'b00)));
    step(NOP, 1'b0, 1'b0);
    chk("rst_outs_a", 32'(outs_a()), 32'(e_ok(2'b00, 2'b00)));
    chk("rst_cnts_a", {stall_cnt_a, flush_cnt_a}, 32'd0);
    chk("rst_cnts_b", 32'({stall_cnt_b, flush_cnt_b}), 32'd0);

    // Forwarding / load-use / branch table on the default configuration
    for (int k = 0; k < 16; k++) begin
      step(tbl[k].i, tbl[k].br, 1'b0);
      chk($sformatf("vec%0d_a", k), 32'(outs_a()), 32'(tbl[k].exp));
    end
    chk("tbl_stall_cnt_a", 32'(stall_cnt_a), 32'd1);
    chk("tbl_flush_cnt_a", 32'(flush_cnt_a), 32'd1);

    // No forwarding: producer must drain through WB
    do_reset();
    step(alu(7, 1, 1), 1'b0, 1'b0);
    chk("nofwd_s0_b", 32'(outs_b()), 32'(e_ok(2'b00, 2'b00)));
    for (int k = 1; k <= 3; k++) begin
      step(alu(8, 7, 0), 1'b0, 1'b0);
      chk($sformatf("nofwd_s%0d_b", k), 32'(outs_b()), 32'(E_STALL));
    end
    step(alu(8, 7, 0), 1'b0, 1'b0);
    chk("nofwd_release_b", 32'(outs_b()), 32'(e_ok(2'b00, 2'b00)));
    chk("nofwd_stall_cnt_b", 32'(stall_cnt_b), 32'd3);
    step(NOP, 1'b1, 1'b0);
    chk("br_ex_b", 32'(outs_b()), 32'(E_FLUSH2));
    step(NOP, 1'b0, 1'b0);
    chk("br_ex_flush_cnt_b", 32'(flush_cnt_b), 32'd1);

    // Twenty load-use stalls: 16-bit counter reaches 20, 4-bit holds at 15
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step(lw(2, 0), 1'b0, 1'b0);
      step(alu(3, 2, 4), 1'b0, 1'b0);
    end
    step(NOP, 1'b0, 1'b0);
    chk("sat_stall_cnt_a", 32'(stall_cnt_a), 32'd20);
    chk("sat_stall_cnt_b", 32'(stall_cnt_b), 32'd15);
    chk("sat_flush_cnt_b", 32'(flush_cnt_b), 32'd0);

    // Reset in the middle of a stall, then a branch in the post-reset cycle
    step(lw(2, 0), 1'b0, 1'b0);
    step(alu(3, 2, 4), 1'b0, 1'b0);
    chk("pre_rst_stall_a", 32'(outs_a()), 32'(E_STALL));
    step(alu(3, 2, 4), 1'b0, 1'b1);
    chk("in_rst_outs_a", 32'(outs_a()), 32'(e_ok(2'b00, 2'b00)));
    step(alu(3, 2, 4), 1'b1, 1'b0);
    chk("post_rst_outs_a", 32'(outs_a()), 32'(e_ok(2'b00, 2'b00)));
    chk("post_rst_outs_b", 32'(outs_b()), 32'(e_ok(2'b00, 2'b00)));
    chk("post_rst_cnts_a", {stall_cnt_a, flush_cnt_a}, 32'd0);
    step(NOP, 1'b0, 1'b0);
    chk("post_rst2_cnts_a", {stall_cnt_a, flush_cnt_a}, 32'd0);
    chk("post_rst2_cnts_b", 32'({stall_cnt_b, flush_cnt_b}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
